// File: rtl/sort_pkg.sv
// Shared constants and types for the max-scan sorting controller.
package sort_pkg;

    localparam int N     = 8;
    localparam int W     = 16;
    localparam int IDX_W = $clog2(N);

    typedef enum logic [2:0] {IDLE, SCAN, PICK, OUT, DONE} scan_state_t;

    typedef logic [W-1:0] elem_t;

endpackage

// File: rtl/onehot_encoder.sv
// Binary encoder for a one-hot vector plus a flag telling whether the input
// really is one-hot (exactly one bit set).
module onehot_encoder #(
    parameter  int N     = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             onehot_ok
);

    always_comb begin
        idx       = '0;
        onehot_ok = (vec != '0) && ((vec & (vec - 1'b1)) == '0);
        // OR-encoding is exact only for one-hot input; callers gate on onehot_ok.
        for (int k = 0; k < N; k++) begin
            if (vec[k]) begin
                idx = idx | IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/max_scan_ctrl.sv
// Descending-order sorter: bit-plane scan narrows chi to the maxima, the external
// selection chain picks one, the winner is emitted and dropped, N times over.
module max_scan_ctrl
    import sort_pkg::*;
#(
    parameter  int N     = sort_pkg::N,
    parameter  int W     = sort_pkg::W,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [N*W-1:0]   i_data,
    output logic             o_busy,
    output logic [N-1:0]     o_chi,
    output logic             o_chi_vld,
    input  logic [N-1:0]     i_pick,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx,
    output logic [W-1:0]     o_data,
    input  logic             i_ready,
    output logic             o_done,
    output logic             o_err,
    output scan_state_t      o_state
);

    localparam int BW = $clog2(W);
    localparam logic [BW-1:0]    BIT_MSB = BW'(W - 1);
    localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(N - 1);

    scan_state_t      state_q;
    logic [W-1:0]     data_q [N];
    logic [N-1:0]     active_q;
    logic [N-1:0]     winner_q;
    logic [BW-1:0]    bit_q;
    logic [IDX_W-1:0] cnt_q;

    logic [N-1:0]     plane;
    logic [N-1:0]     cand;
    logic [N-1:0]     chi_low;
    logic [IDX_W-1:0] chi_low_idx;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_onehot;
    logic             pick_legal;
    logic [N-1:0]     winner_c;
    logic [IDX_W-1:0] win_idx;
    logic [N-1:0]     active_next;

    assign o_state = state_q;

    always_comb begin
        plane = '0;
        for (int k = 0; k < N; k++) begin
            plane[k] = data_q[k][bit_q];
        end
    end

    assign cand = o_chi & plane;

    // Fallback winner when the chain misbehaves: lowest candidate in chi.
    always_comb begin
        chi_low     = '0;
        chi_low_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (o_chi[k]) begin
                chi_low     = '0;
                chi_low[k]  = 1'b1;
                chi_low_idx = IDX_W'(k);
            end
        end
    end

    onehot_encoder #(.N(N)) u_pick_enc (
        .vec       (i_pick),
        .idx       (pick_idx),
        .onehot_ok (pick_onehot)
    );

    assign pick_legal  = pick_onehot && ((i_pick & ~o_chi) == '0);
    assign winner_c    = pick_legal ? i_pick   : chi_low;
    assign win_idx     = pick_legal ? pick_idx : chi_low_idx;
    assign active_next = active_q & ~winner_q;

    // Result handshake: o_valid stays high with o_idx/o_data frozen until a cycle
    // with o_valid & i_ready; that cycle is the transfer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            for (int k = 0; k < N; k++) begin
                data_q[k] <= '0;
            end
            active_q  <= '0;
            winner_q  <= '0;
            bit_q     <= '0;
            cnt_q     <= '0;
            o_busy    <= 1'b0;
            o_chi     <= '0;
            o_chi_vld <= 1'b0;
            o_valid   <= 1'b0;
            o_idx     <= '0;
            o_data    <= '0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        for (int k = 0; k < N; k++) begin
                            data_q[k] <= i_data[k*W +: W];
                        end
                        active_q <= '1;
                        o_chi    <= '1;
                        bit_q    <= BIT_MSB;
                        cnt_q    <= '0;
                        o_err    <= 1'b0;
                        o_busy   <= 1'b1;
                        state_q  <= SCAN;
                    end
                end
                SCAN: begin
                    if (|cand) begin
                        o_chi <= cand;
                    end
                    if (bit_q == '0) begin
                        o_chi_vld <= 1'b1;
                        state_q   <= PICK;
                    end else begin
                        bit_q <= bit_q - 1'b1;
                    end
                end
                PICK: begin
                    winner_q  <= winner_c;
                    o_idx     <= win_idx;
                    o_data    <= data_q[win_idx];
                    if (!pick_legal) begin
                        o_err <= 1'b1;
                    end
                    o_chi_vld <= 1'b0;
                    o_valid   <= 1'b1;
                    state_q   <= OUT;
                end
                OUT: begin
                    if (i_ready) begin
                        o_valid  <= 1'b0;
                        active_q <= active_next;
                        cnt_q    <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            o_chi   <= active_next;
                            bit_q   <= BIT_MSB;
                            state_q <= SCAN;
                        end
                    end
                end
                DONE: begin
                    o_done  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_max_scan_ctrl.sv
// Directed bench for max_scan_ctrl (N=4, W=4) with a lowest-index-priority chain model.
module tb_max_scan_ctrl;
    import sort_pkg::*;

    localparam int N     = 4;
    localparam int W     = 4;
    localparam int IDX_W = 2;
    localparam int EW    = IDX_W + W;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             i_start;
    logic [N*W-1:0]   i_data;
    logic [N-1:0]     i_pick;
    logic             i_ready;
    logic             o_busy;
    logic [N-1:0]     o_chi;
    logic             o_chi_vld;
    logic             o_valid;
    logic [IDX_W-1:0] o_idx;
    logic [W-1:0]     o_data;
    logic             o_done;
    logic             o_err;
    scan_state_t      o_state;

    logic             force_zero;
    int               cyc = 0;
    int               start_cyc;
    int               n_checks = 0;
    int               n_err = 0;

    logic [EW-1:0]    exp_q[$];
    logic [N-1:0]     exp_chi_q[$];
    logic [EW-1:0]    got_q[$];
    logic [N-1:0]     first_chi;
    logic             chi_seen;

    logic             hold_prev;
    logic [IDX_W-1:0] prev_idx;
    logic [W-1:0]     prev_data;

    max_scan_ctrl #(.N(N), .W(W)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (i_start),
        .i_data    (i_data),
        .o_busy    (o_busy),
        .o_chi     (o_chi),
        .o_chi_vld (o_chi_vld),
        .i_pick    (i_pick),
        .o_valid   (o_valid),
        .o_idx     (o_idx),
        .o_data    (o_data),
        .i_ready   (i_ready),
        .o_done    (o_done),
        .o_err     (o_err),
        .o_state   (o_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    // Selection chain: lowest index in chi wins.
    function automatic logic [N-1:0] lowest_bit(input logic [N-1:0] v);
        logic [N-1:0] r;
        r = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (v[k]) begin
                r    = '0;
                r[k] = 1'b1;
            end
        end
        return r;
    endfunction

    assign i_pick = force_zero ? '0 : lowest_bit(o_chi);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model: repeated argmax, lowest index on ties ----------------
    task automatic model_load(input logic [N*W-1:0] d);
        logic [W-1:0] v [N];
        logic [N-1:0] rem;
        logic [N-1:0] mask;
        logic [W-1:0] mx;
        int           pick;
        exp_q.delete();
        exp_chi_q.delete();
        for (int k = 0; k < N; k++) v[k] = d[k*W +: W];
        rem = '1;
        for (int s = 0; s < N; s++) begin
            mx = '0;
            for (int k = 0; k < N; k++) if (rem[k] && v[k] >= mx) mx = v[k];
            mask = '0;
            pick = -1;
            for (int k = 0; k < N; k++) begin
                if (rem[k] && v[k] == mx) begin
                    mask[k] = 1'b1;
                    if (pick < 0) pick = k;
                end
            end
            exp_chi_q.push_back(mask);
            exp_q.push_back({IDX_W'(pick), v[pick]});
            rem[pick] = 1'b0;
        end
    endtask

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", 32'(o_valid), 1);
                check("hold_idx", 32'(o_idx), 32'(prev_idx));
                check("hold_data", 32'(o_data), 32'(prev_data));
                check("hold_state", 32'(o_state), 32'(OUT));
            end
            hold_prev = o_valid && !i_ready;
            prev_idx  = o_idx;
            prev_data = o_data;
            if (o_chi_vld) begin
                check("chi_expected", 32'(exp_chi_q.size() != 0), 1);
                if (exp_chi_q.size() != 0) check("chi", 32'(o_chi), 32'(exp_chi_q.pop_front()));
                if (!chi_seen) begin
                    first_chi = o_chi;
                    chi_seen  = 1'b1;
                end
            end
            if (o_valid && i_ready) begin
                check("res_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    logic [EW-1:0] r;
                    r = exp_q.pop_front();
                    check("res_idx", 32'(o_idx), 32'(r[EW-1:W]));
                    check("res_data", 32'(o_data), 32'(r[W-1:0]));
                end
                got_q.push_back({o_idx, o_data});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_sort(input logic [N*W-1:0] d);
        @(posedge clk);
        #1;
        i_data   = d;
        i_start  = 1'b1;
        got_q.delete();
        chi_seen = 1'b0;
        model_load(d);
        @(posedge clk);
        #1;
        i_start   = 1'b0;
        start_cyc = cyc;
        check("busy_after_start", 32'(o_busy), 1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!o_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("valid_seen", 32'(o_valid), 1);
    endtask

    task automatic wait_done(output int el);
        int n = 0;
        while (!o_done && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_seen", 32'(o_done), 1);
        el = cyc - start_cyc;
        check("busy_in_done", 32'(o_busy), 0);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(o_done), 0);
        check("idle_after_done", 32'(o_state), 32'(IDLE));
        check("model_drained", exp_q.size(), 0);
    endtask

    task automatic check_seq(input string name, input logic [EW-1:0] l0, input logic [EW-1:0] l1,
                             input logic [EW-1:0] l2, input logic [EW-1:0] l3);
        logic [EW-1:0] lit [4];
        lit = '{l0, l1, l2, l3};
        check({name, "_count"}, got_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < got_q.size()) check({name, "_item"}, 32'(got_q[k]), 32'(lit[k]));
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_busy"}, 32'(o_busy), 0);
        check({name, "_chi"}, 32'(o_chi), 0);
        check({name, "_chi_vld"}, 32'(o_chi_vld), 0);
        check({name, "_valid"}, 32'(o_valid), 0);
        check({name, "_idx"}, 32'(o_idx), 0);
        check({name, "_data"}, 32'(o_data), 0);
        check({name, "_done"}, 32'(o_done), 0);
        check({name, "_err"}, 32'(o_err), 0);
        check({name, "_state"}, 32'(o_state), 32'(IDLE));
    endtask

    task automatic sort_3951();
        int el;
        start_sort({4'd1, 4'd5, 4'd9, 4'd3});
        wait_valid();
        check("first_valid_latency", cyc - start_cyc, W + 1);
        wait_done(el);
        check("done_latency", el, N * (W + 2));
        check_seq("seq_3951", {2'd1, 4'd9}, {2'd2, 4'd5}, {2'd0, 4'd3}, {2'd3, 4'd1});
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int el;
        i_start    = 1'b0;
        i_data     = '0;
        i_ready    = 1'b1;
        force_zero = 1'b0;
        hold_prev  = 1'b0;
        chi_seen   = 1'b0;
        #1 rst = 1'b1;
        #2 check_idle_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1: basic sort with exact timing
        sort_3951();

        // 2: ties, plus an ignored i_start while scanning
        start_sort({4'd7, 4'd2, 4'd7, 4'd7});
        @(posedge clk);
        #1;
        i_data  = '1;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        check("ignored_start_busy", 32'(o_busy), 1);
        wait_done(el);
        check("first_chi_ties", 32'(first_chi), 32'(4'b1011));
        check_seq("seq_ties", {2'd0, 4'd7}, {2'd1, 4'd7}, {2'd3, 4'd7}, {2'd2, 4'd2});

        // 3: all zero
        start_sort('0);
        wait_done(el);
        check("first_chi_zero", 32'(first_chi), 32'(4'b1111));
        check("err_zero", 32'(o_err), 0);
        check_seq("seq_zero", {2'd0, 4'd0}, {2'd1, 4'd0}, {2'd2, 4'd0}, {2'd3, 4'd0});

        // 4: consumer stall in OUT
        i_ready = 1'b0;
        start_sort({4'd6, 4'd8, 4'd12, 4'd4});
        wait_valid();
        repeat (5) @(posedge clk);
        #1;
        check("stall_state", 32'(o_state), 32'(OUT));
        check("stall_valid", 32'(o_valid), 1);
        check("stall_chi_vld", 32'(o_chi_vld), 0);
        i_ready = 1'b1;
        wait_done(el);
        check("done_latency_stall", el, N * (W + 2) + 5);
        check_seq("seq_stall", {2'd1, 4'd12}, {2'd2, 4'd8}, {2'd3, 4'd6}, {2'd0, 4'd4});

        // 5: illegal (zero) pick falls back to lowest chi bit and sets sticky error
        force_zero = 1'b1;
        start_sort({4'd1, 4'd9, 4'd9, 4'd1});
        wait_valid();
        force_zero = 1'b0;
        check("fallback_idx", 32'(o_idx), 1);
        check("fallback_data", 32'(o_data), 9);
        check("err_set", 32'(o_err), 1);
        wait_done(el);
        check("first_chi_fallback", 32'(first_chi), 32'(4'b0110));
        check("err_sticky", 32'(o_err), 1);
        check_seq("seq_fallback", {2'd1, 4'd9}, {2'd2, 4'd9}, {2'd0, 4'd1}, {2'd3, 4'd1});

        // 6: asynchronous reset mid-scan, then a clean sort
        start_sort({4'd1, 4'd5, 4'd9, 4'd3});
        check("err_cleared_by_start", 32'(o_err), 0);
        @(posedge clk);
        #1;
        check("pre_reset_state", 32'(o_state), 32'(SCAN));
        #1 rst = 1'b1;
        #1 check_idle_outputs("async_reset");
        exp_q.delete();
        exp_chi_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        sort_3951();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
